// File: rtl/snake_pixel_mixer_pkg.sv
// Shared definitions for the snake display: game-over modes, default colours
// and the visible-area geometry also used by VGA_Controller.
package snake_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        GO_FREEZE = 2'd0,
        GO_BLINK  = 2'd1,
        GO_INVERT = 2'd2
    } go_mode_e;

    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] RGB_RED    = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN  = 24'h00FF00;
    localparam logic [23:0] RGB_BLUE   = 24'h0000FF;
    localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;

    // Mode code 3 is unused by the game logic and behaves as a frozen scene.
    function automatic go_mode_e decode_go_mode(input logic [1:0] code);
        case (code)
            2'd1:    return GO_BLINK;
            2'd2:    return GO_INVERT;
            default: return GO_FREEZE;
        endcase
    endfunction

endpackage

// File: rtl/snake_pixel_mixer_blink_timer.sv
// Frame counter driving the game-over blink: counts vSync falling edges and
// flips blink_phase every BLINK_FRAMES frames while game_over is held.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic game_over,
    output logic blink_phase
);

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt;
    logic       vsync_q;
    logic       game_over_q;
    logic       vsync_fall;
    logic       game_over_rise;
    logic       wrap;

    assign vsync_fall     = vsync_q & ~vsync;
    assign game_over_rise = game_over & ~game_over_q;
    assign wrap           = vsync_fall && (frame_cnt >= LAST_FRAME);

    // A fresh game over restarts the count with the phase showing red at once;
    // this takes precedence over a coincident vSync edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q     <= 1'b1;
            game_over_q <= 1'b0;
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            game_over_q <= game_over;
            if (game_over_rise) begin
                frame_cnt   <= 8'd0;
                blink_phase <= 1'b1;
            end else begin
                if (wrap)
                    frame_cnt <= 8'd0;
                else if (vsync_fall)
                    frame_cnt <= frame_cnt + 8'd1;

                if (!game_over)
                    blink_phase <= 1'b0;
                else if (wrap)
                    blink_phase <= ~blink_phase;
            end
        end
    end

endmodule

// File: rtl/snake_pixel_mixer.sv
// Pixel compositor between the VGA timing controller and the DAC: layer
// priority, border/background and game-over effects in a 2-stage pipeline.
module snake_pixel_mixer
    import snake_pkg::*;
#(
    parameter int XW           = 10,
    parameter int CW           = 8,
    parameter int NUM_LAYERS   = 4,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int BORDER_W     = 31,
    parameter logic [NUM_LAYERS*3*CW-1:0] LAYER_RGB =
        {NUM_LAYERS{{CW{1'b1}}, {CW{1'b1}}, {CW{1'b1}}}},
    parameter logic [3*CW-1:0] BORDER_RGB = {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}},
    parameter logic [3*CW-1:0] BG_RGB     = {{CW{1'b0}}, {CW{1'b0}}, {CW{1'b1}}},
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  VGA_clk,
    input  logic                  reset,
    input  logic [XW-1:0]         xCount,
    input  logic [XW-1:0]         yCount,
    input  logic                  displayArea,
    input  logic                  hSync_in,
    input  logic                  vSync_in,
    input  logic                  blank_n_in,
    input  logic [NUM_LAYERS-1:0] layer_hit,
    input  logic                  game_over,
    input  logic [1:0]            go_mode,
    output logic [CW-1:0]         VGA_R,
    output logic [CW-1:0]         VGA_G,
    output logic [CW-1:0]         VGA_B,
    output logic                  VGA_hSync,
    output logic                  VGA_vSync,
    output logic                  blank_n
);

    localparam logic [XW-1:0] X_LO = XW'(BORDER_W);
    localparam logic [XW-1:0] X_HI = XW'(H_ACTIVE - BORDER_W);
    localparam logic [XW-1:0] Y_LO = XW'(BORDER_W);
    localparam logic [XW-1:0] Y_HI = XW'(V_ACTIVE - BORDER_W);
    localparam logic [3*CW-1:0] FULL_RED = {{CW{1'b1}}, {(2*CW){1'b0}}};

    logic                  border_now;
    logic                  s1_border;
    logic [NUM_LAYERS-1:0] s1_hit;
    logic                  s1_display;
    logic                  s1_hsync;
    logic                  s1_vsync;
    logic                  s1_blank_n;
    logic                  s1_game_over;
    go_mode_e              s1_mode;
    logic                  blink_phase;
    logic [3*CW-1:0]       scene_rgb;
    logic [3*CW-1:0]       pixel_rgb;
    logic [3*CW-1:0]       pixel_q;

    assign border_now = (xCount < X_LO) || (xCount >= X_HI) ||
                        (yCount < Y_LO) || (yCount >= Y_HI);

    // Stage 1: capture pixel attributes so they line up with blink_phase.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            s1_border    <= 1'b0;
            s1_hit       <= '0;
            s1_display   <= 1'b0;
            s1_hsync     <= 1'b1;
            s1_vsync     <= 1'b1;
            s1_blank_n   <= 1'b0;
            s1_game_over <= 1'b0;
            s1_mode      <= GO_FREEZE;
        end else begin
            s1_border    <= border_now;
            s1_hit       <= layer_hit;
            s1_display   <= displayArea;
            s1_hsync     <= hSync_in;
            s1_vsync     <= vSync_in;
            s1_blank_n   <= blank_n_in;
            s1_game_over <= game_over;
            s1_mode      <= decode_go_mode(go_mode);
        end
    end

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk         (VGA_clk),
        .reset       (reset),
        .vsync       (vSync_in),
        .game_over   (game_over),
        .blink_phase (blink_phase)
    );

    // Walk from the lowest priority layer upward so layer 0 overrides all.
    always_comb begin
        scene_rgb = s1_border ? BORDER_RGB : BG_RGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_hit[i])
                scene_rgb = LAYER_RGB[i*3*CW +: 3*CW];
        end
    end

    always_comb begin
        pixel_rgb = scene_rgb;
        if (!s1_display) begin
            pixel_rgb = '0;
        end else if (s1_game_over) begin
            case (s1_mode)
                GO_BLINK:  if (blink_phase) pixel_rgb = FULL_RED;
                GO_INVERT: pixel_rgb = ~scene_rgb;
                default:   pixel_rgb = scene_rgb;
            endcase
        end
    end

    // Stage 2: colour and the delayed syncs leave together.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            pixel_q   <= '0;
            VGA_hSync <= 1'b1;
            VGA_vSync <= 1'b1;
            blank_n   <= 1'b0;
        end else begin
            pixel_q   <= pixel_rgb;
            VGA_hSync <= s1_hsync;
            VGA_vSync <= s1_vsync;
            blank_n   <= s1_blank_n;
        end
    end

    assign VGA_R = pixel_q[3*CW-1 -: CW];
    assign VGA_G = pixel_q[2*CW-1 -: CW];
    assign VGA_B = pixel_q[CW-1:0];

endmodule

// File: tb/tb_snake_pixel_mixer.sv
// Scoreboard bench for snake_pixel_mixer: directed and random pixels checked
// against a frame-counting reference model two clocks later.
module tb_snake_pixel_mixer;

    localparam int CW = 8;
    localparam int NL = 4;
    localparam int BF = 2;
    localparam logic [23:0] L0 = 24'hFFFF00;
    localparam logic [23:0] L1 = 24'h00FFFF;
    localparam logic [23:0] L2 = 24'hFF8000;
    localparam logic [23:0] L3 = 24'h808080;
    localparam logic [23:0] BORDER_C = 24'h00FF00;
    localparam logic [23:0] BG_C     = 24'h0000FF;
    localparam logic [23:0] RED_C    = 24'hFF0000;

    typedef struct packed {
        logic       rst;
        logic [9:0] x;
        logic [9:0] y;
        logic       da;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [3:0] hit;
        logic       go;
        logic [1:0] mode;
    } stim_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    logic          VGA_clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    xCount = '0;
    logic [9:0]    yCount = '0;
    logic          displayArea = 1'b0;
    logic          hSync_in = 1'b1;
    logic          vSync_in = 1'b1;
    logic          blank_n_in = 1'b0;
    logic [NL-1:0] layer_hit = '0;
    logic          game_over = 1'b0;
    logic [1:0]    go_mode = 2'd0;
    logic [CW-1:0] VGA_R, VGA_G, VGA_B;
    logic          VGA_hSync, VGA_vSync, blank_n;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   m_prev_vs = 1'b1;
    bit   m_prev_go = 1'b0;
    int   m_falls = 0;

    snake_pixel_mixer #(
        .XW           (10),
        .CW           (CW),
        .NUM_LAYERS   (NL),
        .H_ACTIVE     (640),
        .V_ACTIVE     (480),
        .BORDER_W     (31),
        .LAYER_RGB    ({L3, L2, L1, L0}),
        .BORDER_RGB   (BORDER_C),
        .BG_RGB       (BG_C),
        .BLINK_FRAMES (BF)
    ) dut (
        .VGA_clk     (VGA_clk),
        .reset       (reset),
        .xCount      (xCount),
        .yCount      (yCount),
        .displayArea (displayArea),
        .hSync_in    (hSync_in),
        .vSync_in    (vSync_in),
        .blank_n_in  (blank_n_in),
        .layer_hit   (layer_hit),
        .game_over   (game_over),
        .go_mode     (go_mode),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_hSync   (VGA_hSync),
        .VGA_vSync   (VGA_vSync),
        .blank_n     (blank_n)
    );

    always #5 VGA_clk = ~VGA_clk;

    function automatic stim_t mk(bit rst, int x, int y, bit da, logic [3:0] hit,
                                 bit go, logic [1:0] mode, bit vs, bit hs);
        stim_t s;
        s.rst = rst;  s.x = 10'(x);  s.y = 10'(y);  s.da = da;  s.hs = hs;
        s.vs = vs;    s.bl = da;     s.hit = hit;   s.go = go;  s.mode = mode;
        return s;
    endfunction

    // Colour straight from the compositing rules.
    function automatic logic [23:0] model_rgb(stim_t s, bit phase);
        logic [23:0] layers [NL];
        logic [23:0] c;
        bit          border;
        layers = '{L0, L1, L2, L3};
        if (!s.da) return 24'h000000;
        border = (s.x < 31) || (s.x >= 640 - 31) || (s.y < 31) || (s.y >= 480 - 31);
        c = border ? BORDER_C : BG_C;
        for (int i = 0; i < NL; i++) begin
            if (s.hit[i]) begin
                c = layers[i];
                break;
            end
        end
        if (s.go) begin
            if (s.mode == 2'd1 && phase) c = RED_C;
            else if (s.mode == 2'd2)     c = ~c;
        end
        return c;
    endfunction

    // Phase is red for the first BF frames after a game-over rise, then alternates.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   phase;
        @(negedge VGA_clk);
        reset = s.rst;  xCount = s.x;  yCount = s.y;  displayArea = s.da;
        hSync_in = s.hs;  vSync_in = s.vs;  blank_n_in = s.bl;
        layer_hit = s.hit;  game_over = s.go;  go_mode = s.mode;
        if (s.rst) begin
            m_prev_vs = 1'b1;
            m_prev_go = 1'b0;
            m_falls   = 0;
            e = '{rgb: 24'h000000, hs: 1'b1, vs: 1'b1, bl: 1'b0};
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = e;
            exp_q.push_back(e);
        end else begin
            if (s.go && !m_prev_go)       m_falls = 0;
            else if (m_prev_vs && !s.vs)  m_falls++;
            phase = ((m_falls / BF) % 2) == 0;
            e.rgb = model_rgb(s, phase);
            e.hs  = s.hs;
            e.vs  = s.vs;
            e.bl  = s.bl;
            m_prev_vs = s.vs;
            m_prev_go = s.go;
            exp_q.push_back(e);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== e.rgb) begin
            n_fail++;
            $display("[TB] FAIL pixel_rgb at %0t: got %h expected %h", $time, {VGA_R, VGA_G, VGA_B}, e.rgb);
        end
        n_checks++;
        if ({VGA_hSync, VGA_vSync, blank_n} !== {e.hs, e.vs, e.bl}) begin
            n_fail++;
            $display("[TB] FAIL sync_blank at %0t: got %b expected %b", $time,
                     {VGA_hSync, VGA_vSync, blank_n}, {e.hs, e.vs, e.bl});
        end
    endtask

    task automatic checkTimer(input logic [7:0] cnt, input logic phase);
        n_checks++;
        if (dut.u_blink_timer.frame_cnt !== cnt || dut.u_blink_timer.blink_phase !== phase) begin
            n_fail++;
            $display("[TB] FAIL timer_state: got cnt=%0d phase=%b expected cnt=%0d phase=%b",
                     dut.u_blink_timer.frame_cnt, dut.u_blink_timer.blink_phase, cnt, phase);
        end
    endtask

    always @(posedge VGA_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int xs [4];
        bit go_r;
        logic [1:0] mode_r;
        xs = '{30, 31, 608, 609};

        // Reset at start, then a few pixels, then a 3-cycle reset mid-line.
        repeat (3) applyStimulus(mk(1, 0, 0, 0, 4'h0, 0, 0, 1, 1));
        for (int i = 0; i < 4; i++) applyStimulus(mk(0, 200 + i, 100, 1, 4'h0, 0, 0, 1, 1));
        repeat (3) applyStimulus(mk(1, 204, 100, 1, 4'h0, 0, 0, 1, 1));
        for (int i = 0; i < 4; i++) applyStimulus(mk(0, 205 + i, 100, 1, 4'h0, 0, 0, 1, i != 1));

        // Priority, border, background, blanking.
        applyStimulus(mk(0, 100, 100, 1, 4'b0110, 0, 0, 1, 1));
        applyStimulus(mk(0, 100, 100, 1, 4'b1000, 0, 0, 1, 1));
        applyStimulus(mk(0, 10, 200, 1, 4'b0000, 0, 0, 1, 1));
        applyStimulus(mk(0, 320, 240, 1, 4'b0000, 0, 0, 1, 1));
        foreach (xs[i]) applyStimulus(mk(0, xs[i], 240, 1, 4'h0, 0, 0, 1, 1));
        applyStimulus(mk(0, 320, 30, 1, 4'h0, 0, 0, 1, 1));
        applyStimulus(mk(0, 320, 449, 1, 4'h0, 0, 0, 1, 1));
        applyStimulus(mk(0, 320, 240, 0, 4'b0001, 1, 2, 1, 1));

        // Invert mode on a background pixel, then on a layer pixel, then release.
        applyStimulus(mk(0, 320, 240, 1, 4'h0, 1, 2, 1, 1));
        applyStimulus(mk(0, 320, 240, 1, 4'b0100, 1, 2, 1, 1));
        applyStimulus(mk(0, 320, 240, 1, 4'h0, 0, 2, 1, 1));

        // Game-over rise coinciding with a vSync fall after a clean reset.
        repeat (2) applyStimulus(mk(1, 320, 240, 1, 4'h0, 0, 1, 1, 1));
        repeat (2) applyStimulus(mk(0, 320, 240, 1, 4'h0, 0, 1, 1, 1));
        applyStimulus(mk(0, 320, 240, 1, 4'h0, 1, 1, 0, 1));
        @(posedge VGA_clk);
        #1;
        checkTimer(8'd0, 1'b1);

        // Blink over 8 frames: red and scene alternate every BF frames.
        for (int f = 0; f < 8; f++) begin
            repeat (4) applyStimulus(mk(0, 320, 240, 1, 4'h0, 1, 1, 1, 1));
            repeat (2) applyStimulus(mk(0, 320, 240, 1, 4'h0, 1, 1, 0, 0));
        end
        applyStimulus(mk(0, 320, 240, 1, 4'h0, 0, 1, 1, 1));
        applyStimulus(mk(0, 320, 240, 1, 4'h0, 0, 1, 1, 1));

        // Randomised traffic with slowly changing game-over state.
        go_r = 1'b0;
        mode_r = 2'd1;
        for (int n = 0; n < 2000; n++) begin
            stim_t s;
            int x;
            if ($urandom_range(0, 39) == 0) go_r = ~go_r;
            if ($urandom_range(0, 19) == 0) mode_r = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? xs[$urandom_range(0, 3)] : int'($urandom_range(0, 639));
            s = mk($urandom_range(0, 299) == 0, x, $urandom_range(0, 479),
                   $urandom_range(0, 7) != 0,
                   ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                   go_r, mode_r, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0);
            applyStimulus(s);
        end

        repeat (3) applyStimulus(mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 1));
        @(posedge VGA_clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
